// File: rtl/spi_pixel_fifo.sv
// SPI image upload front end: assembles RGB565 pixels from a byte stream, tags them
// with their screen position and buffers them in a first-word-fall-through FIFO.
module spi_pixel_fifo #(
    parameter int X_RES     = 800,
    parameter int Y_RES     = 600,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_frame_start,
    input  logic                 spi_byte_valid,
    input  logic [7:0]           spi_byte,
    output logic                 pixel_ready,
    output logic [37:0]          pixel_data,
    input  logic                 pixel_read,
    output logic [ADDR_BITS:0]   fifo_count,
    output logic                 overflow,
    output logic                 image_done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [10:0]        X_LAST     = 11'(X_RES - 1);
    localparam logic [10:0]        Y_LAST     = 11'(Y_RES - 1);
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    state_t                 state, next_state;
    logic                   phase;
    logic [7:0]             hi_byte;
    logic [10:0]            x, y;
    logic [37:0]            mem [DEPTH];
    logic [ADDR_BITS-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_BITS:0]     count, count_next;
    logic                   ready_q;
    logic                   byte_take, pix_done, last_pix, pop, push_ok;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        next_state = state;
        byte_take  = (state == LOAD) && spi_byte_valid && !spi_frame_start;
        pix_done   = byte_take && phase;
        last_pix   = pix_done && (x == X_LAST) && (y == Y_LAST);
        if (spi_frame_start)
            next_state = LOAD;
        else if (last_pix)
            next_state = DONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Byte pairing and position counters; positions freeze once the final pixel is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= 1'b0;
            hi_byte    <= 8'h00;
            x          <= 11'd0;
            y          <= 11'd0;
            image_done <= 1'b0;
        end else begin
            image_done <= last_pix;
            if (spi_frame_start) begin
                phase <= 1'b0;
                x     <= 11'd0;
                y     <= 11'd0;
            end else if (byte_take) begin
                phase <= !phase;
                if (!phase)
                    hi_byte <= spi_byte;
                else if (!last_pix) begin
                    if (x == X_LAST) begin
                        x <= 11'd0;
                        y <= y + 11'd1;
                    end else begin
                        x <= x + 11'd1;
                    end
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop        = pixel_read && ready_q;
        push_ok    = pix_done && ((count != FULL_COUNT) || pop);
        count_next = count;
        if (push_ok && !pop)
            count_next = count + 1'b1;
        else if (pop && !push_ok)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ready_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != '0);
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (spi_frame_start)
                overflow <= 1'b0;
            else if (pix_done && !push_ok)
                overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; entries are only observed behind pixel_ready.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {x, y, hi_byte, spi_byte};
    end

    assign pixel_data  = mem[rd_ptr];
    assign pixel_ready = ready_q;
    assign fifo_count  = count;

endmodule

// File: tb/tb_spi_pixel_fifo.sv
// Directed bench for spi_pixel_fifo on a 4x3 image with a 16-entry FIFO.
module tb_spi_pixel_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_frame_start, spi_byte_valid, pixel_read;
    logic [7:0]  spi_byte;
    logic        pixel_ready, overflow, image_done;
    logic [37:0] pixel_data;
    logic [4:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    spi_pixel_fifo #(.X_RES(4), .Y_RES(3), .DEPTH(16), .ADDR_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .spi_frame_start(spi_frame_start), .spi_byte_valid(spi_byte_valid), .spi_byte(spi_byte),
        .pixel_ready(pixel_ready), .pixel_data(pixel_data), .pixel_read(pixel_read),
        .fifo_count(fifo_count), .overflow(overflow), .image_done(image_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        v;
        logic [7:0]  b;
        logic        rd;
        logic        exp_ready;
        logic [37:0] exp_data;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t        vecs[32];
    int          nvec = 0;
    logic [37:0] expq[$];

    function automatic logic [37:0] mk(input int px, input int py, input logic [15:0] rgb);
        return {11'(px), 11'(py), rgb};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fs, input logic v, input logic [7:0] b, input logic rd,
                       input logic er, input logic [37:0] ed, input logic [4:0] ec);
        vecs[nvec] = '{fs: fs, v: v, b: b, rd: rd, exp_ready: er, exp_data: ed, exp_count: ec};
        nvec++;
    endtask

    task automatic cycle(input logic fs, input logic v, input logic [7:0] b, input logic rd);
        spi_frame_start = fs;
        spi_byte_valid  = v;
        spi_byte        = b;
        pixel_read      = rd;
        @(posedge clk);
        #1;
        spi_frame_start = 1'b0;
        spi_byte_valid  = 1'b0;
        pixel_read      = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] rgb, input logic rd_on_lo);
        cycle(1'b0, 1'b1, rgb[15:8], 1'b0);
        cycle(1'b0, 1'b1, rgb[7:0], rd_on_lo);
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), pixel_data, expq.pop_front());
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check({tag, "_empty_ready"}, 38'(pixel_ready), 38'd0);
        check({tag, "_empty_count"}, 38'(fifo_count), 38'd0);
    endtask

    initial begin
        rst = 1'b1;
        spi_frame_start = 1'b0;
        spi_byte_valid  = 1'b0;
        spi_byte        = 8'h00;
        pixel_read      = 1'b0;

        // Single pixel, then a frame start that carries a byte which must be dropped,
        // then five pixels across the line wrap, each popped as the next one starts.
        add(1, 0, 8'h00, 0, 0, '0, 0);
        add(0, 1, 8'hF8, 0, 0, '0, 0);
        add(0, 1, 8'h1F, 0, 1, mk(0, 0, 16'hF81F), 1);
        add(0, 0, 8'h00, 0, 1, mk(0, 0, 16'hF81F), 1);
        add(0, 0, 8'h00, 1, 0, '0, 0);
        add(1, 1, 8'hAA, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 8'h10, (i > 0), 0, '0, 0);
            add(0, 1, 8'(i), 0, 1, mk(i % 4, i / 4, 16'h1000 + 16'(i)), 1);
        end
        add(0, 0, 8'h00, 1, 0, '0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 38'(pixel_ready), 38'd0);
        check("rst_count", 38'(fifo_count), 38'd0);
        check("rst_overflow", 38'(overflow), 38'd0);
        check("rst_done", 38'(image_done), 38'd0);
        rst = 1'b0;
        cycle(1'b0, 1'b1, 8'h55, 1'b0);
        check("idle_byte_ignored", 38'(fifo_count), 38'd0);

        for (int i = 0; i < nvec; i++) begin
            cycle(vecs[i].fs, vecs[i].v, vecs[i].b, vecs[i].rd);
            check($sformatf("vec%0d_ready", i), 38'(pixel_ready), 38'(vecs[i].exp_ready));
            check($sformatf("vec%0d_count", i), 38'(fifo_count), 38'(vecs[i].exp_count));
            check($sformatf("vec%0d_done", i), 38'(image_done), 38'd0);
            if (vecs[i].exp_ready)
                check($sformatf("vec%0d_data", i), pixel_data, vecs[i].exp_data);
        end

        // Image end: 12 pixels with no reads, done pulses only after (3,2).
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send_pixel(16'hA000 + 16'(i), 1'b0);
            expq.push_back(mk(i % 4, i / 4, 16'hA000 + 16'(i)));
            check($sformatf("img_done%0d", i), 38'(image_done), 38'(i == 11));
        end
        cycle(1'b0, 1'b1, 8'hEE, 1'b0);
        check("img_done_after", 38'(image_done), 38'd0);
        cycle(1'b0, 1'b1, 8'hEE, 1'b0);
        check("img_extra_count", 38'(fifo_count), 38'd12);
        check("img_extra_done", 38'(image_done), 38'd0);

        // Overflow: a new frame does not flush; the 17th stored pixel is dropped.
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("ovf_fs_count", 38'(fifo_count), 38'd12);
        for (int i = 0; i < 4; i++) begin
            send_pixel(16'hB000 + 16'(i), 1'b0);
            expq.push_back(mk(i, 0, 16'hB000 + 16'(i)));
        end
        check("ovf_full_count", 38'(fifo_count), 38'd16);
        check("ovf_full_flag", 38'(overflow), 38'd0);
        send_pixel(16'hB004, 1'b0);
        check("ovf_drop_count", 38'(fifo_count), 38'd16);
        check("ovf_drop_flag", 38'(overflow), 38'd1);
        check("ovf_head", pixel_data, expq.pop_front());
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_pop_count", 38'(fifo_count), 38'd15);
        send_pixel(16'hB005, 1'b0);
        expq.push_back(mk(1, 1, 16'hB005));
        check("ovf_next_count", 38'(fifo_count), 38'd16);
        check("ovf_sticky", 38'(overflow), 38'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("ovf_clear_flag", 38'(overflow), 38'd0);
        check("ovf_clear_count", 38'(fifo_count), 38'd16);

        // Full FIFO with push and pop on the same edge.
        cycle(1'b0, 1'b1, 8'hC0, 1'b0);
        check("pp_head", pixel_data, expq.pop_front());
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        expq.push_back(mk(0, 0, 16'hC000));
        check("pp_count", 38'(fifo_count), 38'd16);
        check("pp_overflow", 38'(overflow), 38'd0);
        drain_check("pp");

        // Reset in the middle of an image, with a dangling high byte.
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++)
            send_pixel(16'hD000 + 16'(i), 1'b0);
        cycle(1'b0, 1'b1, 8'hD3, 1'b0);
        check("pre_rst_count", 38'(fifo_count), 38'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 38'(pixel_ready), 38'd0);
        check("mid_rst_count", 38'(fifo_count), 38'd0);
        check("mid_rst_overflow", 38'(overflow), 38'd0);
        check("mid_rst_done", 38'(image_done), 38'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("empty_read_count", 38'(fifo_count), 38'd0);
        check("empty_read_ready", 38'(pixel_ready), 38'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        send_pixel(16'h1234, 1'b0);
        check("post_rst_ready", 38'(pixel_ready), 38'd1);
        check("post_rst_data", pixel_data, mk(0, 0, 16'h1234));
        check("post_rst_count", 38'(fifo_count), 38'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_pixel_fifo.md
# spi_pixel_fifo

- Sits directly upstream of the SRAM write arbiter, on the SPI image path.
- Turns the SPI byte stream of an uploaded image into RGB565 pixels, each tagged with its screen position.
- Buffers those pixels in a small first-word-fall-through FIFO, so pixels are not lost while the arbiter is busy serving foreground read requests.
- Its output uses the same 38-bit `{x, y, pixel}` word and ready/read handshake as the ADC pixel FIFO, so the arbiter consumes both sources identically.

## Interface

Parameters:
- `X_RES`, default 800: pixels per image line.
- `Y_RES`, default 600: lines per image.
- `DEPTH`, default 16: FIFO entries; must be a power of two.
- `ADDR_BITS`, default 4: log2(`DEPTH`).

Ports (name, direction, width, meaning):
- `clk`  in  1: single clock; everything is synchronous to its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `spi_frame_start`  in  1: one-cycle pulse; starts a new image upload.
- `spi_byte_valid`  in  1: `spi_byte` is valid this cycle.
- `spi_byte`  in  8: received SPI byte; the high byte of each pixel comes first.
- `pixel_ready`  out  1: FIFO is non-empty; `pixel_data` is valid.
- `pixel_data`  out  38: `{x[10:0], y[10:0], rgb565[15:0]}` of the FIFO head.
- `pixel_read`  in  1: consumer pops the head this cycle.
- `fifo_count`  out  ADDR_BITS+1: current occupancy, 0..`DEPTH`.
- `overflow`  out  1: sticky flag; a pixel was dropped because the FIFO was full.
- `image_done`  out  1: one-cycle pulse when the last pixel of an image is pushed.

## Operation

State machine, states IDLE / LOAD / DONE:
- Reset value: IDLE.
- Any state → LOAD on `spi_frame_start`:
  - x, y, byte phase and `overflow` clear to 0.
  - A `spi_byte_valid` in the same cycle is discarded.
- In IDLE and DONE, `spi_byte_valid` is ignored.
- LOAD → DONE when pixel (`X_RES`-1, `Y_RES`-1) is assembled.

Byte assembly (LOAD only):
- Phase 0: latch `spi_byte` as the high byte; phase becomes 1.
- Phase 1: form pixel `{hi, spi_byte}`; request a push with the current x, y; phase becomes 0.

Position counters (11-bit unsigned x, y), advanced on every assembled pixel whether or not it is pushed:
- If x == `X_RES`-1: x becomes 0 and y increments.
- Otherwise x increments.
- Final pixel (`X_RES`-1, `Y_RES`-1):
  - `image_done` pulses.
  - State becomes DONE; no further wrap occurs.

FIFO:
- Circular buffer with `rd_ptr` / `wr_ptr` of ADDR_BITS bits that wrap modulo `DEPTH`, plus a count register.
- `pixel_data` is read combinationally as `mem[rd_ptr]`.
- Pop occurs when `pixel_read` && `pixel_ready`. `pixel_read` while empty is ignored; pointers and count are unchanged.
- Push is accepted when `fifo_count` < `DEPTH`, or when a pop occurs in the same cycle.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
- Push while full with no pop: the pixel is dropped and `overflow` is set to 1. It stays set until `spi_frame_start` or `rst`.
- `spi_frame_start` does not flush the FIFO; previous-image pixels drain normally.

Mid-operation events:
- `rst` asserted mid-image clears all of the above immediately.
- `spi_frame_start` mid-image (in LOAD) restarts at (0,0) with phase 0. A dangling high byte is discarded.

## Timing

Reset values:
- `pixel_ready` 0, `fifo_count` 0, `overflow` 0, `image_done` 0.
- `pixel_data` is don't-care whenever `pixel_ready` = 0; the memory is not reset.

Latency:
- Second byte of a pixel accepted at edge N → entry written at N.
- If the FIFO was empty, `pixel_ready` = 1 and `pixel_data` is valid after edge N, i.e. in cycle N+1.

Handshake:
- `pixel_read` sampled high at edge M pops the head.
- The next entry (or `pixel_ready` = 0) is visible in cycle M+1.
- Back-to-back pops every cycle are supported.

Output timing:
- `fifo_count` and `pixel_ready` are registered; `pixel_ready` == (`fifo_count` != 0).
- `image_done` is high for exactly the cycle after the edge that accepts the final pixel's second byte.
- Byte throughput: one `spi_byte_valid` per cycle maximum, giving one pixel every 2 cycles.

## Test plan

- Single pixel:
  - Stimulus: `rst`, `spi_frame_start`, bytes 0xF8 then 0x1F, no reads.
  - Required: `pixel_ready` = 1 in the cycle after the second byte; `pixel_data` = {11'd0, 11'd0, 16'hF81F}; `fifo_count` = 1.
- Line wrap:
  - Stimulus: `X_RES` = 4, `Y_RES` = 3; stream 5 pixels while popping each.
  - Required: positions (0,0) (1,0) (2,0) (3,0) (0,1), in order.
- Image end:
  - Stimulus: `X_RES` = 4, `Y_RES` = 3; 12 pixels, then 2 extra bytes.
  - Required: `image_done` pulses once after pixel (3,2); extra bytes produce no push; state is DONE.
- Overflow:
  - Stimulus: `DEPTH` = 16; push 17 pixels with no reads.
  - Required: `fifo_count` = 16; `overflow` = 1; entries are pixels 0..15; pixel 16 lost; next pixel tagged (x of pixel 17).
  - Then: `spi_frame_start` clears `overflow`; FIFO still holds 16 entries.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; assert `pixel_read` in the same cycle a pixel completes.
  - Required: count stays 16; no overflow; ordering preserved.
- Reset mid-image and empty read:
  - Stimulus: assert `rst` after 3 pixels and 1 extra byte.
  - Required: all outputs at reset values.
  - Then: `pixel_read` while empty leaves `fifo_count` = 0.
  - Then: a new frame starts at (0,0) with the high byte first.
